// File: rtl/bip_control.sv
// bip_control: multi-cycle control unit for a small accumulator machine.
// Each instruction takes three cycles (FETCH, DECODE, EXEC). Opcode 00000
// halts the machine until reset.
// Build option: define BIP_CYCLE_COUNT_EN to add the 16-bit o_cycles counter.
module bip_control #(
  parameter int unsigned PCBITS = 11,
  parameter int unsigned OPBITS = 5,
  parameter int unsigned DTBITS = 11
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [15:0]       i_instr,
  output logic [PCBITS-1:0] o_pc,
  output logic [DTBITS-1:0] o_operand,
  output logic [1:0]        o_sel_a,
  output logic              o_sel_b,
  output logic              o_op,
  output logic              o_wr_acc,
  output logic              o_wr_ram,
  output logic              o_rd_ram,
`ifdef BIP_CYCLE_COUNT_EN
  output logic [15:0]       o_cycles,
`endif
  output logic              o_halt
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StHalt
  } state_e;

  localparam logic [OPBITS-1:0] OpHlt  = OPBITS'(0);
  localparam logic [OPBITS-1:0] OpSto  = OPBITS'(1);
  localparam logic [OPBITS-1:0] OpLd   = OPBITS'(2);
  localparam logic [OPBITS-1:0] OpLdi  = OPBITS'(3);
  localparam logic [OPBITS-1:0] OpAdd  = OPBITS'(4);
  localparam logic [OPBITS-1:0] OpAddi = OPBITS'(5);
  localparam logic [OPBITS-1:0] OpSub  = OPBITS'(6);
  localparam logic [OPBITS-1:0] OpSubi = OPBITS'(7);

  // Accumulator source encodings
  localparam logic [1:0] SelRam = 2'd0;
  localparam logic [1:0] SelImm = 2'd1;
  localparam logic [1:0] SelAlu = 2'd2;

  state_e            state_q, state_d;
  logic [15:0]       ir_q, ir_d;
  logic [PCBITS-1:0] pc_q, pc_d;

  logic [OPBITS-1:0] opcode;
  logic [1:0]        dec_sel_a;
  logic              dec_sel_b;
  logic              dec_op;
  logic              dec_wr_acc;
  logic              dec_wr_ram;
  logic              dec_rd_ram;
  logic              in_exec;

  assign opcode  = ir_q[15 -: OPBITS];
  assign in_exec = (state_q == StExec);

  // Next-state logic: fetch/decode/exec loop, HALT absorbing, start honoured only in IDLE
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    pc_d    = pc_q;
    unique case (state_q)
      StIdle: begin
        if (i_start) state_d = StFetch;
      end
      StFetch: begin
        ir_d    = i_instr;
        state_d = StDecode;
      end
      StDecode: begin
        state_d = (opcode == OpHlt) ? StHalt : StExec;
      end
      StExec: begin
        // Wraps from all-ones to zero without any indication
        pc_d    = pc_q + PCBITS'(1);
        state_d = StFetch;
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, instruction and program counter registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      ir_q    <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      pc_q    <= pc_d;
    end
  end

  // Opcode decode; data-path selects follow IR, undefined opcodes decode as NOP
  always_comb begin
    dec_sel_a  = SelRam;
    dec_sel_b  = 1'b0;
    dec_op     = 1'b0;
    dec_wr_acc = 1'b0;
    dec_wr_ram = 1'b0;
    dec_rd_ram = 1'b0;
    case (opcode)
      OpSto: begin
        dec_wr_ram = 1'b1;
      end
      OpLd: begin
        dec_rd_ram = 1'b1;
        dec_sel_a  = SelRam;
        dec_wr_acc = 1'b1;
      end
      OpLdi: begin
        dec_sel_a  = SelImm;
        dec_wr_acc = 1'b1;
      end
      OpAdd, OpSub: begin
        dec_rd_ram = 1'b1;
        dec_sel_b  = 1'b0;
        dec_sel_a  = SelAlu;
        dec_wr_acc = 1'b1;
        dec_op     = (opcode == OpSub);
      end
      OpAddi, OpSubi: begin
        dec_sel_b  = 1'b1;
        dec_sel_a  = SelAlu;
        dec_wr_acc = 1'b1;
        dec_op     = (opcode == OpSubi);
      end
      default: begin
      end
    endcase
  end

  assign o_pc      = pc_q;
  assign o_operand = ir_q[DTBITS-1:0];
  assign o_sel_a   = dec_sel_a;
  assign o_sel_b   = dec_sel_b;
  assign o_op      = dec_op;
  // Strobes gated so they pulse only during the single EXEC cycle
  assign o_wr_acc  = dec_wr_acc & in_exec;
  assign o_wr_ram  = dec_wr_ram & in_exec;
  assign o_rd_ram  = dec_rd_ram & in_exec;
  assign o_halt    = (state_q == StHalt);

`ifdef BIP_CYCLE_COUNT_EN
  logic [15:0] cycles_q, cycles_d;
  logic        running;

  assign running = (state_q == StFetch) || (state_q == StDecode) || (state_q == StExec);

  // Count active cycles only, saturating at all-ones
  always_comb begin
    cycles_d = cycles_q;
    if (running && (cycles_q != 16'hFFFF)) cycles_d = cycles_q + 16'd1;
  end

  // Cycle counter register
  always_ff @(posedge i_clk) begin
    if (i_rst) cycles_q <= '0;
    else       cycles_q <= cycles_d;
  end

  assign o_cycles = cycles_q;
`endif

endmodule

// File: tb/tb_bip_control.sv
// Directed bench for bip_control; program memory is modelled as an array
// read combinationally at o_pc.
module tb_bip_control;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] instr;
  logic [10:0] pc;
  logic [10:0] operand;
  logic [1:0]  sel_a;
  logic        sel_b, op, wr_acc, wr_ram, rd_ram, halt;
`ifdef BIP_CYCLE_COUNT_EN
  logic [15:0] cycles;
`endif

  logic [15:0] mem [2048];
  int n_vec = 0;
  int n_err = 0;

  assign instr = mem[pc];

  always #5 clk = ~clk;

  bip_control dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_start   (start),
    .i_instr   (instr),
    .o_pc      (pc),
    .o_operand (operand),
    .o_sel_a   (sel_a),
    .o_sel_b   (sel_b),
    .o_op      (op),
    .o_wr_acc  (wr_acc),
    .o_wr_ram  (wr_ram),
    .o_rd_ram  (rd_ram),
`ifdef BIP_CYCLE_COUNT_EN
    .o_cycles  (cycles),
`endif
    .o_halt    (halt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 2048; i++) mem[i] = 16'hF800;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Pulse start for the edge that leaves IDLE; afterwards the DUT is in FETCH
  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    fill_nop();

    // Reset state
    do_reset();
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_operand", 32'(operand), 32'h0);
    check("rst_sel_a", 32'(sel_a), 32'h0);
    check("rst_selb_op", 32'({sel_b, op}), 32'h0);
    check("rst_strobes", 32'({wr_acc, wr_ram, rd_ram}), 32'h0);
    check("rst_halt", 32'(halt), 32'h0);
`ifdef BIP_CYCLE_COUNT_EN
    check("rst_cycles", 32'(cycles), 32'h0);
`endif
    run(3);
    check("idle_hold_pc", 32'(pc), 32'h0);

    // LDI 5 ; HLT
    mem[0] = 16'h1805;
    mem[1] = 16'h0000;
    go();                                   // cycle 1: FETCH
    check("ldi_fetch_strobes", 32'({wr_acc, wr_ram, rd_ram}), 32'h0);
    tick();                                 // cycle 2: DECODE
    check("ldi_dec_sel_a", 32'(sel_a), 32'h1);
    check("ldi_dec_strobes", 32'({wr_acc, wr_ram, rd_ram}), 32'h0);
    tick();                                 // cycle 3: EXEC
    check("ldi_exec_sel_a", 32'(sel_a), 32'h1);
    check("ldi_exec_strobes", 32'({wr_acc, wr_ram, rd_ram}), 32'h4);
    check("ldi_exec_operand", 32'(operand), 32'h005);
    tick();                                 // cycle 4: FETCH of HLT
    check("ldi_next_pc", 32'(pc), 32'h1);
    check("ldi_fetch2_strobes", 32'({wr_acc, wr_ram, rd_ram}), 32'h0);
    tick();                                 // cycle 5: DECODE of HLT
    check("hlt_decode_halt", 32'(halt), 32'h0);
    tick();
    check("hlt_halt", 32'(halt), 32'h1);
    check("hlt_pc", 32'(pc), 32'h1);
    check("hlt_strobes", 32'({wr_acc, wr_ram, rd_ram}), 32'h0);
`ifdef BIP_CYCLE_COUNT_EN
    check("hlt_cycles", 32'(cycles), 32'd5);
`endif
    start = 1'b1;
    run(4);
    start = 1'b0;
    check("hlt_absorb_halt", 32'(halt), 32'h1);
    check("hlt_absorb_pc", 32'(pc), 32'h1);
`ifdef BIP_CYCLE_COUNT_EN
    check("hlt_cycles_frozen", 32'(cycles), 32'd5);
`endif

    // ADDI 7FF ; SUB 3 ; HLT
    mem[0] = 16'h2FFF;
    mem[1] = 16'h3003;
    mem[2] = 16'h0000;
    do_reset();
    check("rst2_halt", 32'(halt), 32'h0);
    check("rst2_pc", 32'(pc), 32'h0);
    go();
    run(2);                                 // EXEC of ADDI
    check("addi_sel_b", 32'(sel_b), 32'h1);
    check("addi_op", 32'(op), 32'h0);
    check("addi_sel_a", 32'(sel_a), 32'h2);
    check("addi_operand", 32'(operand), 32'h7FF);
    check("addi_strobes", 32'({wr_acc, wr_ram, rd_ram}), 32'h4);
    run(3);                                 // EXEC of SUB
    check("sub_strobes", 32'({wr_acc, wr_ram, rd_ram}), 32'h5);
    check("sub_op", 32'(op), 32'h1);
    check("sub_sel_b", 32'(sel_b), 32'h0);
    check("sub_sel_a", 32'(sel_a), 32'h2);
    check("sub_operand", 32'(operand), 32'h003);

    // NOP(11111) ; STO 12 ; LD 34 ; SUBI 2 ; ADD 9 ; HLT
    mem[0] = 16'hF800;
    mem[1] = 16'h0812;
    mem[2] = 16'h1034;
    mem[3] = 16'h3802;
    mem[4] = 16'h2009;
    mem[5] = 16'h0000;
    do_reset();
    go();
    run(2);                                 // EXEC of NOP
    check("nop_strobes", 32'({wr_acc, wr_ram, rd_ram}), 32'h0);
    check("nop_pc_before", 32'(pc), 32'h0);
    tick();
    check("nop_pc_after", 32'(pc), 32'h1);
    run(2);                                 // EXEC of STO
    check("sto_strobes", 32'({wr_acc, wr_ram, rd_ram}), 32'h2);
    run(3);                                 // EXEC of LD
    check("ld_strobes", 32'({wr_acc, wr_ram, rd_ram}), 32'h5);
    check("ld_sel_a", 32'(sel_a), 32'h0);
    run(3);                                 // EXEC of SUBI
    check("subi_strobes", 32'({wr_acc, wr_ram, rd_ram}), 32'h4);
    check("subi_selb_op", 32'({sel_b, op}), 32'h3);
    check("subi_sel_a", 32'(sel_a), 32'h2);
    run(3);                                 // EXEC of ADD
    check("add_strobes", 32'({wr_acc, wr_ram, rd_ram}), 32'h5);
    check("add_selb_op", 32'({sel_b, op}), 32'h0);
    run(3);
    check("prog3_halt", 32'(halt), 32'h1);
    check("prog3_pc", 32'(pc), 32'h5);

    // Reset during EXEC of STO discards strobe and PC increment
    do_reset();
    go();
    run(5);                                 // EXEC of STO at address 1
    check("sto2_wr_ram", 32'(wr_ram), 32'h1);
    check("sto2_pc", 32'(pc), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_wr_ram", 32'(wr_ram), 32'h0);
    check("midrst_pc", 32'(pc), 32'h0);
    check("midrst_operand", 32'(operand), 32'h0);
    check("midrst_halt", 32'(halt), 32'h0);
    run(3);                                 // idle without start
    check("midrst_idle_pc", 32'(pc), 32'h0);
    check("midrst_idle_strobes", 32'({wr_acc, wr_ram, rd_ram}), 32'h0);

    // PC wrap over NOP-filled memory
    fill_nop();
    do_reset();
    go();
    run(2047 * 3);
    check("wrap_pc_max", 32'(pc), 32'h7FF);
    run(3);
    check("wrap_pc_zero", 32'(pc), 32'h0);
    check("wrap_halt", 32'(halt), 32'h0);
    run(3);
    check("wrap_continue", 32'(pc), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bip_control.md
BIP_CONTROL -- requirements
Module: bip_control

Interface
REQ-001 Parameter PCBITS, default 11: program counter width.
REQ-002 Parameter OPBITS, default 5: opcode field width, instruction bits [15:11].
REQ-003 Parameter DTBITS, default 11: operand field width, instruction bits [10:0], fed to the sign extender.
REQ-004 i_clk  input  1  single clock; all state changes on its rising edge.
REQ-005 i_rst  input  1  synchronous reset, active-high.
REQ-006 i_start  input  1  run request; sampled only in IDLE.
REQ-007 i_instr  input  16  program memory read data for address o_pc.
REQ-008 o_pc  output  PCBITS  program memory address.
REQ-009 o_operand  output  DTBITS  instruction operand; drives the sign extender input.
REQ-010 o_sel_a  output  2  accumulator source: 0 = RAM, 1 = extended operand, 2 = ALU.
REQ-011 o_sel_b  output  1  ALU B source: 0 = RAM, 1 = extended operand.
REQ-012 o_op  output  1  ALU operation: 0 = add, 1 = subtract.
REQ-013 o_wr_acc, o_wr_ram, o_rd_ram  output  1 each  one-cycle write/read strobes.
REQ-014 o_halt  output  1  high while in HALT.

Function
REQ-015 FSM states: IDLE, FETCH, DECODE, EXEC, HALT.
REQ-016 IDLE -> FETCH when i_start=1; otherwise remain in IDLE.
REQ-017 FETCH: o_pc stable; the instruction register captures i_instr at the end of the cycle; -> DECODE.
REQ-018 DECODE: o_operand = IR[10:0] registered; o_sel_a, o_sel_b, o_op valid; -> EXEC, or -> HALT if opcode = 00000.
REQ-019 EXEC: strobes asserted for exactly this one cycle; o_pc increments at the end of the cycle; -> FETCH.
REQ-020 Instruction period: 3 cycles per non-halt instruction.
REQ-021 Opcode 00001 STO: o_wr_ram=1.
REQ-022 Opcode 00010 LD: o_rd_ram=1, o_sel_a=0, o_wr_acc=1.
REQ-023 Opcode 00011 LDI: o_sel_a=1, o_wr_acc=1.
REQ-024 Opcodes 00100 ADD / 00110 SUB: o_rd_ram=1, o_sel_b=0, o_sel_a=2, o_wr_acc=1, o_op=0/1.
REQ-025 Opcodes 00101 ADDI / 00111 SUBI: o_sel_b=1, o_sel_a=2, o_wr_acc=1, o_op=0/1.
REQ-026 Undefined opcodes execute as NOP: no strobes, PC still increments.
REQ-027 Strobes are 0 in every state except EXEC.
REQ-028 PC wrap-around: 2^PCBITS-1 increments to 0 with no error indication.
REQ-029 HALT is absorbing: only i_rst leaves it; i_start is ignored; o_pc holds the HLT address.
REQ-030 i_start changes outside IDLE have no effect.

Reset
REQ-031 i_rst=1 at a rising edge forces, on that edge: state IDLE, o_pc=0, IR=0, o_operand=0, o_sel_a=0, o_sel_b=0, o_op=0, all strobes 0, o_halt=0.
REQ-032 Reset has priority over every transition, including mid-EXEC: the pending strobes and PC increment are discarded.

Configuration
REQ-033 Macro BIP_CYCLE_COUNT_EN defined: adds output o_cycles (16 bits), reset to 0, incrementing once per cycle in FETCH/DECODE/EXEC, frozen in IDLE and HALT, saturating at 16'hFFFF.
REQ-034 BIP_CYCLE_COUNT_EN undefined: o_cycles port and counter are absent; all other behaviour is identical.

Verification
REQ-035 Reset, then i_start=1, program {LDI 11'h005, HLT} -> EXEC shows o_sel_a=1, o_wr_acc=1, o_operand=11'h005; halt on the 5th cycle after start; o_pc=1.
REQ-036 Program {ADDI 11'h7FF, SUB 11'h003} -> ADDI EXEC shows o_sel_b=1, o_op=0, o_operand=11'h7FF; SUB EXEC shows o_rd_ram=1, o_op=1.
REQ-037 Opcode 11111 -> no strobes in EXEC, o_pc advances by 1.
REQ-038 Preload PC path to 2047 (NOP-filled memory) -> o_pc goes 2047 -> 0, execution continues.
REQ-039 Assert i_rst during EXEC of STO -> o_wr_ram=0 in the following cycle, state IDLE, o_pc=0.
REQ-040 With BIP_CYCLE_COUNT_EN defined, program {LDI 1, HLT} -> o_cycles=5 after halt and stays 5.
